// File: rtl/pif_xbus_master.sv
// pif_xbus_master: turns I2C PHY command bytes into register-bus cycles and serves readback bytes once the responders have settled.
module pif_xbus_master #(
  parameter int TYPE_BITS = 2,
  parameter int DATA_BITS = 6,
  parameter int SUB_W     = 4,
  parameter int READ_LAT  = 5
) (
  input  logic                         xclk,
  input  logic                         xrst,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_start,
  input  logic                         tx_req,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  output logic [2*DATA_BITS+SUB_W:0]   XI,
  input  logic [7:0]                   XO
);
  localparam int CW = $clog2(READ_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
  state_t state, state_nx;
  logic [TYPE_BITS-1:0] typ;
  logic [DATA_BITS-1:0] payload, prwa, pd;
  logic [SUB_W-1:0] prdsuba;
  logic [CW-1:0] scnt;
  logic pwr, set_addr, wr, set_sub, cmd, send_go, done;
  assign typ      = rx_data[7:DATA_BITS];
  assign payload  = rx_data[DATA_BITS-1:0];
  assign set_addr = rx_valid && typ == TYPE_BITS'(0);
  assign wr       = rx_valid && typ == TYPE_BITS'(1);
  assign set_sub  = rx_valid && typ == TYPE_BITS'(2);
  assign cmd      = set_addr || wr || set_sub;
  // any incoming byte holds off the read, even a reserved one
  assign send_go  = state == WAIT && scnt == '0 && !rx_valid && !rx_start;
  assign done     = state == SEND && !rx_start;
  assign XI       = {pwr, prwa, pd, prdsuba};
  always_comb begin
    state_nx = rx_start ? IDLE :
               state == IDLE ? (tx_req ? WAIT : IDLE) :
               state == WAIT ? (send_go ? SEND : WAIT) : IDLE;
  end
  always_ff @(posedge xclk) begin
    if (xrst) begin
      state    <= IDLE;
      pwr      <= 1'b0;
      prwa     <= '0;
      pd       <= '0;
      prdsuba  <= '0;
      scnt     <= CW'(READ_LAT);
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nx;
      pwr      <= wr;
      prwa     <= set_addr ? payload : prwa;
      pd       <= wr ? payload : pd;
      prdsuba  <= set_addr ? '0 : set_sub ? payload[SUB_W-1:0] : done ? prdsuba + 1'b1 : prdsuba;
      scnt     <= (cmd || done) ? CW'(READ_LAT) : scnt == '0 ? '0 : scnt - 1'b1;
      tx_valid <= send_go;
      tx_data  <= send_go ? XO : tx_data;
    end
  end
endmodule

// File: tb/tb_pif_xbus_master.sv
// tb_pif_xbus_master: directed plus randomized checks of the register-bus master against a timing/data model.
module tb_pif_xbus_master;
  localparam int RL = 5;
  logic xclk, xrst, rx_valid, rx_start, tx_req, tx_valid;
  logic [7:0] rx_data, tx_data, XO;
  logic [16:0] XI;
  logic [7:0] xo_pipe [RL] = '{default: 8'h00};
  int cyc = 0, checks = 0, failures = 0;
  int last_chg, req_edge;
  logic [5:0] m_prwa, m_pd;
  logic [3:0] m_sub;

  pif_xbus_master dut (
    .xclk(xclk), .xrst(xrst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_start(rx_start),
    .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data), .XI(XI), .XO(XO)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;
  always @(posedge xclk) cyc <= cyc + 1;

  // responder: RL-stage pipeline, data depends on sub-address and low address bits
  always @(posedge xclk) begin
    xo_pipe[0] <= (8'h50 + {4'h0, XI[3:0]}) ^ {XI[13:10], 4'h0};
    for (int i = 1; i < RL; i++) xo_pipe[i] <= xo_pipe[i-1];
  end
  assign XO = xo_pipe[RL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xi_exp(input logic pw);
    return {15'h0, pw, m_prwa, m_pd, m_sub};
  endfunction

  task automatic send_byte(input int t, input logic [5:0] p);
    rx_valid = 1'b1;
    rx_data  = {t[1:0], p};
    @(negedge xclk);
    rx_valid = 1'b0;
    if (t == 0) begin m_prwa = p; m_sub = 4'h0; end
    if (t == 1) m_pd = p;
    if (t == 2) m_sub = p[3:0];
    if (t != 3) last_chg = cyc;
    chk("xi_cmd", 32'(XI), xi_exp(t == 1));
    @(negedge xclk);
    chk("xi_hold", 32'(XI), xi_exp(1'b0));
  endtask

  task automatic wait_read(input bit hold);
    int t, exp_t;
    logic [7:0] exp_d;
    for (int k = 0; k < 40 && !tx_valid; k++) @(negedge xclk);
    chk("rd_seen", 32'(tx_valid), 32'd1);
    t = cyc;
    exp_t = (req_edge + 1 > last_chg + RL + 1) ? req_edge + 1 : last_chg + RL + 1;
    exp_d = (8'h50 + {4'h0, m_sub}) ^ {m_prwa[3:0], 4'h0};
    chk("rd_edge", 32'(t), 32'(exp_t));
    chk("rd_data", 32'(tx_data), 32'(exp_d));
    if (!hold) tx_req = 1'b0;
    m_sub = m_sub + 4'h1;
    last_chg = t + 1;
    req_edge = t + 2;
    @(negedge xclk);
    chk("rd_pulse", 32'(tx_valid), 32'd0);
    chk("rd_xi", 32'(XI), xi_exp(1'b0));
  endtask

  task automatic start_read();
    tx_req = 1'b1;
    req_edge = cyc + 1;
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge xclk);
      seen = seen | tx_valid;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    xrst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_start = 1'b0; tx_req = 1'b0;
    m_prwa = '0; m_pd = '0; m_sub = '0;
    repeat (3) @(negedge xclk);
    chk("rst_xi", 32'(XI), 32'd0);
    chk("rst_tv", 32'(tx_valid), 32'd0);
    chk("rst_td", 32'(tx_data), 32'd0);
    last_chg = cyc;
    xrst = 1'b0;
    send_byte(0, 6'h01);
    send_byte(1, 6'h15);
    send_byte(0, 6'h00);
    start_read();
    wait_read(1'b1);
    wait_read(1'b1);
    wait_read(1'b0);
    send_byte(2, 6'h0F);
    start_read();
    wait_read(1'b0);
    start_read();
    wait_read(1'b0);
    repeat (10) @(negedge xclk);
    start_read();
    wait_read(1'b0);
    repeat (10) @(negedge xclk);
    start_read();
    send_byte(2, 6'h03);
    wait_read(1'b0);
    send_byte(0, 6'h02);
    start_read();
    repeat (2) @(negedge xclk);
    rx_start = 1'b1;
    tx_req = 1'b0;
    @(negedge xclk);
    rx_start = 1'b0;
    quiet(10, "start_no_tv");
    chk("start_xi", 32'(XI), xi_exp(1'b0));
    start_read();
    wait_read(1'b0);
    for (int n = 0; n < 25; n++) begin
      send_byte(int'($urandom_range(0, 3)), 6'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 8)) @(negedge xclk);
        start_read();
        wait_read(1'b0);
      end
    end
    send_byte(0, 6'h0A);
    send_byte(3, 6'h2A);
    send_byte(2, 6'h05);
    start_read();
    repeat (2) @(negedge xclk);
    xrst = 1'b1;
    @(negedge xclk);
    m_prwa = '0; m_pd = '0; m_sub = '0;
    last_chg = cyc;
    chk("mrst_xi", 32'(XI), 32'd0);
    chk("mrst_td", 32'(tx_data), 32'd0);
    xrst = 1'b0;
    tx_req = 1'b0;
    quiet(10, "mrst_no_tv");
    start_read();
    wait_read(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
